// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one overlapping "101" Moore detector.
// Optional SEQ_SCHED_ABORT_EN: dropping req mid-frame aborts it.
module seq_det_sched #(
  parameter int NREQ      = 4,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4,
  parameter int ID_W      = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  din,
  output logic [NREQ-1:0]  gnt,
  output logic             busy,
  output logic             det_out,
  output logic             done,
  output logic [ID_W-1:0]  done_id,
  output logic [CNT_W-1:0] match_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    REPORT
  } st_t;

  typedef enum logic [1:0] {
    S0,
    S1,
    S10,
    S101
  } det_t;

  st_t r_st;
  st_t w_st_nxt;
  det_t r_det;
  det_t w_det_nxt;

  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  r_last;
  logic [ID_W-1:0]  r_done_id;
  logic [NREQ-1:0]  r_gnt;
  logic [7:0]       r_bits;
  logic [CNT_W-1:0] r_cnt;

  logic [ID_W-1:0] w_win;
  logic [ID_W-1:0] w_idx;
  logic            w_found;
  logic            w_bit;
  logic            w_last_bit;
  logic            w_abort;

  // Walk farthest-to-nearest so the nearest requester after r_last wins.
  always_comb begin
    w_win   = r_last;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = ID_W'((int'(r_last) + k) % NREQ);
      if (req[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_bit      = din[r_id];
  assign w_last_bit = (r_bits == 8'(FRAME_LEN - 1));

`ifdef SEQ_SCHED_ABORT_EN
  assign w_abort = ~req[r_id];
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_det_nxt = S0;
    unique case (r_det)
      S0:      w_det_nxt = w_bit ? S1   : S0;
      S1:      w_det_nxt = w_bit ? S1   : S10;
      S10:     w_det_nxt = w_bit ? S101 : S0;
      S101:    w_det_nxt = w_bit ? S1   : S10;
      default: w_det_nxt = S0;
    endcase
  end

  always_comb begin
    w_st_nxt = r_st;
    unique case (r_st)
      IDLE: begin
        if (w_found) w_st_nxt = RUN;
      end
      RUN: begin
        if (w_abort)         w_st_nxt = IDLE;
        else if (w_last_bit) w_st_nxt = REPORT;
      end
      REPORT:  w_st_nxt = IDLE;
      default: w_st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_st <= IDLE;
    else      r_st <= w_st_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_id      <= '0;
      r_last    <= ID_W'(NREQ - 1);
      r_done_id <= '0;
      r_gnt     <= '0;
      r_bits    <= '0;
      r_cnt     <= '0;
      r_det     <= S0;
    end else begin
      unique case (r_st)
        IDLE: begin
          if (w_found) begin
            r_id   <= w_win;
            r_last <= w_win;
            r_gnt  <= NREQ'(1) << w_win;
            r_bits <= '0;
            r_cnt  <= '0;
            r_det  <= S0;
          end
        end
        RUN: begin
          if (w_abort) begin
            r_gnt <= '0;
            r_det <= S0;
          end else begin
            r_bits <= r_bits + 8'd1;
            r_det  <= w_det_nxt;
            // Saturate instead of wrapping.
            if (w_det_nxt == S101 && r_cnt != '1)
              r_cnt <= r_cnt + 1'b1;
            if (w_last_bit) begin
              r_gnt     <= '0;
              r_done_id <= r_id;
            end
          end
        end
        REPORT:  r_det <= S0;
        default: r_det <= S0;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign busy      = (r_st != IDLE);
  assign done      = (r_st == REPORT);
  assign det_out   = (r_det == S101);
  assign done_id   = r_done_id;
  assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: vector table, random frames vs.
// a round-robin/"101"-count model, plus multi-cycle corner cases.
module tb_seq_det_sched;

  localparam int NREQ = 4;
  localparam int FL   = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, din, gnt;
  logic       busy, det_out, done;
  logic [1:0] done_id;
  logic [3:0] match_cnt;

  logic [3:0] req2, din2, gnt2;
  logic       busy2, det2, done2;
  logic [1:0] id2;
  logic [1:0] cnt2;

  int n_chk  = 0;
  int n_fail = 0;
  int mdl_last;

  always #5 clk = ~clk;

  seq_det_sched #(
    .NREQ(4), .FRAME_LEN(8), .CNT_W(4)
  ) u_dut (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(gnt), .busy(busy), .det_out(det_out),
    .done(done), .done_id(done_id),
    .match_cnt(match_cnt)
  );

  seq_det_sched #(
    .NREQ(4), .FRAME_LEN(16), .CNT_W(2)
  ) u_sat (
    .clk(clk), .rst(rst), .req(req2), .din(din2),
    .gnt(gnt2), .busy(busy2), .det_out(det2),
    .done(done2), .done_id(id2),
    .match_cnt(cnt2)
  );

  typedef struct {
    logic [3:0] rq;
    logic [7:0] bits;
    int         eid;
    int         ecnt;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [3:0] r);
    for (int k = 1; k <= NREQ; k++)
      if (r[(mdl_last + k) % NREQ])
        return (mdl_last + k) % NREQ;
    return -1;
  endfunction

  // Sample k of a frame is bits[7-k] (literal reads in time order).
  function automatic bit is101(input logic [7:0] b,
                               input int k);
    if (k < 2) return 1'b0;
    return b[9-k] && !b[8-k] && b[7-k];
  endfunction

  function automatic int cnt101(input logic [7:0] b);
    int c = 0;
    for (int k = 0; k < FL; k++)
      if (is101(b, k)) c++;
    return c;
  endfunction

  function automatic int gnt_idx(input logic [3:0] g);
    for (int i = 0; i < NREQ; i++)
      if (g[i]) return i;
    return -1;
  endfunction

  task automatic run_frame(input string nm,
                           input logic [3:0] rq,
                           input logic [7:0] bits,
                           input int eid,
                           input int ecnt);
    bit got = 1'b0;
    req = rq;
    for (int w = 0; w < 20 && !got; w++) begin
      tick();
      if (gnt != 0) got = 1'b1;
    end
    chk({nm, " grant_seen"}, 32'(got), 1);
    if (!got) begin
      req = 0;
      return;
    end
    chk({nm, " gnt"}, gnt, 4'b1 << eid);
    chk({nm, " busy"}, busy, 1);
    for (int k = 0; k < FL; k++) begin
      din = (k % 2 == 0) ? 4'b1010 : 4'b0101;
      din[eid] = bits[7-k];
      tick();
      if (k < FL - 1) begin
        chk({nm, " det_out"}, det_out, is101(bits, k));
        chk({nm, " gnt_run"}, gnt, 4'b1 << eid);
        chk({nm, " no_done"}, done, 0);
      end
    end
    chk({nm, " done"}, done, 1);
    chk({nm, " done_id"}, done_id, eid);
    chk({nm, " match_cnt"}, match_cnt, ecnt);
    chk({nm, " gnt_report"}, gnt, 0);
    req = 0;
    din = 0;
    tick();
    chk({nm, " done_drop"}, done, 0);
    chk({nm, " id_held"}, done_id, eid);
    chk({nm, " cnt_held"}, match_cnt, ecnt);
    chk({nm, " idle"}, busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    mdl_last = NREQ - 1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int rise_t[8];
    int rise_id[8];
    int nrise;
    int m;
    bit got;
    logic [3:0] prev;
    logic [3:0] rq;
    logic [7:0] bits;
    int eid;

    vt[0] = '{4'b0001, 8'b10101101, 0, 3};
    vt[1] = '{4'b1111, 8'b00000000, 1, 0};
    vt[2] = '{4'b0100, 8'b11111111, 2, 0};
    vt[3] = '{4'b1001, 8'b10101010, 3, 3};
    vt[4] = '{4'b0110, 8'b10110101, 1, 3};
    vt[5] = '{4'b0100, 8'b00000101, 2, 1};

    rst = 1'b0;
    req = 0; din = 0; req2 = 0; din2 = 0;
    #12;
    chk("rst gnt", gnt, 0);
    chk("rst busy", busy, 0);
    chk("rst det_out", det_out, 0);
    chk("rst done", done, 0);
    chk("rst done_id", done_id, 0);
    chk("rst match_cnt", match_cnt, 0);
    tick();
    rst = 1'b1;
    mdl_last = NREQ - 1;

    for (int i = 0; i < 6; i++) begin
      run_frame($sformatf("vec%0d", i), vt[i].rq,
                vt[i].bits, vt[i].eid, vt[i].ecnt);
      mdl_last = vt[i].eid;
    end

    for (int i = 0; i < 16; i++) begin
      rq   = 4'($urandom_range(1, 15));
      bits = 8'($urandom);
      eid  = rr_pick(rq);
      run_frame($sformatf("rnd%0d", i), rq, bits,
                eid, cnt101(bits));
      mdl_last = eid;
    end

    // All four requesting constantly.
    do_reset();
    req = 4'b1111;
    nrise = 0;
    prev = 0;
    for (int c = 0; c < 50; c++) begin
      din = 4'($urandom);
      tick();
      chk("rr onehot", 32'($countones(gnt) <= 1), 1);
      if (prev == 0 && gnt != 0 && nrise < 8) begin
        rise_t[nrise]  = c;
        rise_id[nrise] = gnt_idx(gnt);
        nrise++;
      end
      prev = gnt;
    end
    req = 0;
    chk("rr grants", 32'(nrise >= 5), 1);
    if (nrise >= 5)
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("rr id%0d", i), rise_id[i], i % 4);
        if (i > 0)
          chk($sformatf("rr gap%0d", i),
              rise_t[i] - rise_t[i-1], 10);
      end

    // Reset in the middle of a frame.
    do_reset();
    req = 4'b0010;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      tick();
      if (gnt != 0) got = 1'b1;
    end
    chk("mrst grant", gnt, 4'b0010);
    din = 4'b0010; tick();
    din = 4'b0000; tick();
    din = 4'b0010; tick();
    chk("mrst pre det", det_out, 1);
    chk("mrst pre cnt", match_cnt, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mrst gnt", gnt, 0);
    chk("mrst busy", busy, 0);
    chk("mrst det", det_out, 0);
    chk("mrst done", done, 0);
    chk("mrst cnt", match_cnt, 0);
    chk("mrst id", done_id, 0);
    req = 0;
    tick();
    rst = 1'b1;
    for (int w = 0; w < 10; w++) begin
      tick();
      chk("mrst no_done", done, 0);
    end
    req = 4'b0001;
    tick();
    chk("mrst regrant", gnt, 4'b0001);
    req = 4'b0001;
    for (int w = 0; w < 12; w++) tick();
    req = 0;
    tick();

    // Requester 1 drops req after three samples.
    do_reset();
    req = 4'b0010;
    tick();
    chk("abt grant", gnt, 4'b0010);
    din = 4'b0010; tick();
    din = 4'b0000; tick();
    din = 4'b0010; tick();
    din = 4'b0000;
    req = 4'b0000;
    tick();
`ifdef SEQ_SCHED_ABORT_EN
    chk("abt busy", busy, 0);
    chk("abt gnt", gnt, 0);
    chk("abt done", done, 0);
    chk("abt partial", match_cnt, 1);
`else
    got = done;
    for (int w = 0; w < 10 && !got; w++) begin
      tick();
      got = done;
    end
    chk("abt done_seen", 32'(got), 1);
    chk("abt done_id", done_id, 1);
    chk("abt cnt", match_cnt, 1);
    tick();
`endif
    req = 4'b0011;
    tick();
    chk("abt next", gnt, 4'b0001);
    for (int w = 0; w < FL; w++) tick();
    req = 0;
    tick();
    tick();

    // Saturating counter instance.
    req2 = 4'b0001;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      tick();
      if (gnt2 != 0) got = 1'b1;
    end
    chk("sat grant", gnt2, 4'b0001);
    m = 0;
    for (int k = 0; k < 16; k++) begin
      din2 = {3'b000, 1'(k % 2 == 0)};
      tick();
      if (k >= 2 && k % 2 == 0) m++;
      if (k < 15)
        chk($sformatf("sat cnt%0d", k), cnt2,
            (m > 3) ? 3 : m);
    end
    chk("sat done", done2, 1);
    chk("sat final", cnt2, 3);
    req2 = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
